// File: rtl/intc_pkg.sv
// Shared interrupt-controller parameters and helpers for the NMI conditioning path.
package intc_pkg;

    localparam int CPU_NUM_DEF = 4;
    localparam int FILT_W_DEF  = 4;

    // Polarity-normalised NMI level: 1 means "NMI asserted" regardless of pin polarity.
    function automatic logic nmi_norm(input logic pin_lvl, input logic pol);
        return ~(pin_lvl ^ pol);
    endfunction

endpackage

// File: rtl/intc_nmi_filter_ch.sv
// One NMI channel: 2-flop sync, polarity normalise, stability filter, arm gate, sticky glitch flag.
// Latency: pin to level is 3 + filt_len_i edges; enable drop gates the output combinationally.
// Backpressure: none; level output, capture stage downstream handles edge/hold.
module intc_nmi_filter_ch
    import intc_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nmi_pin_i,
    input  logic              nmi_pol_i,
    input  logic              nmi_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              glitch_clr_i,
    output logic              intreq_nmi_o,
    output logic              nmi_glitch_o
);

    // Sync cells: the pin is asynchronous to clk.
    (* async_reg = "true" *) logic s1_q;
    (* async_reg = "true" *) logic s2_q;
    logic              s1_d;
    logic              s2_d;
    logic              stable_q;
    logic              stable_d;
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;
    logic              armed_q;
    logic              armed_d;
    logic              glitch_q;
    logic              glitch_d;
    logic              norm;
    logic              glitch_set;

    assign norm = nmi_norm(s2_q, nmi_pol_i);

    always_comb begin
        s1_d       = nmi_pin_i;
        s2_d       = s1_q;
        stable_d   = stable_q;
        cnt_d      = cnt_q;
        glitch_set = 1'b0;

        if (norm == stable_q) begin
            // Level returned before acceptance: the pending change was abandoned.
            cnt_d      = '0;
            glitch_set = (cnt_q != '0);
        end else if (cnt_q >= filt_len_i) begin
            stable_d = norm;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        armed_d = armed_q;
        if (!nmi_en_i) begin
            armed_d = 1'b0;
        end else if (!stable_q) begin
            armed_d = 1'b1;
        end
    end

    always_comb begin
        glitch_d = glitch_q | glitch_set;
        if (glitch_clr_i) begin
            glitch_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            glitch_q <= glitch_d;
        end
    end

    assign intreq_nmi_o = stable_q & armed_q & nmi_en_i;
    assign nmi_glitch_o = glitch_q;

endmodule

// File: rtl/intc_nmi_filter.sv
// Per-CPU NMI input conditioner: one independent filter channel per CPU.
// Latency: 3 + filt_len_i edges pin to intreq_nmi_o; enable drop is same-cycle.
// Backpressure: none; drives levels into the NMI capture stage.
module intc_nmi_filter
    import intc_pkg::*;
#(
    parameter int CPU_NUM = CPU_NUM_DEF,
    parameter int FILT_W  = FILT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CPU_NUM-1:0] nmi_pin_i,
    input  logic [CPU_NUM-1:0] nmi_pol_i,
    input  logic [CPU_NUM-1:0] nmi_en_i,
    input  logic [FILT_W-1:0]  filt_len_i,
    input  logic [CPU_NUM-1:0] glitch_clr_i,
    output logic [CPU_NUM-1:0] intreq_nmi_o,
    output logic [CPU_NUM-1:0] nmi_glitch_o
);

    for (genvar g = 0; g < CPU_NUM; g++) begin : g_ch
        intc_nmi_filter_ch #(
            .FILT_W (FILT_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .nmi_pin_i    (nmi_pin_i[g]),
            .nmi_pol_i    (nmi_pol_i[g]),
            .nmi_en_i     (nmi_en_i[g]),
            .filt_len_i   (filt_len_i),
            .glitch_clr_i (glitch_clr_i[g]),
            .intreq_nmi_o (intreq_nmi_o[g]),
            .nmi_glitch_o (nmi_glitch_o[g])
        );
    end

endmodule

// File: tb/tb_intc_nmi_filter.sv
module tb_intc_nmi_filter;

    localparam int N  = 4;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  pin;
    logic [N-1:0]  pol;
    logic [N-1:0]  en;
    logic [N-1:0]  clr;
    logic [FW-1:0] flen;
    logic [N-1:0]  intreq;
    logic [N-1:0]  glitch;

    int checks   = 0;
    int failures = 0;

    // Reference model: pin history queue, accepted level, run length of differing samples.
    logic [N-1:0] pipe[$];
    logic [N-1:0] m_acc;
    logic [N-1:0] m_arm;
    logic [N-1:0] m_gl;
    int           m_run[N];

    always #5 clk = ~clk;

    intc_nmi_filter #(
        .CPU_NUM (N),
        .FILT_W  (FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .nmi_pin_i    (pin),
        .nmi_pol_i    (pol),
        .nmi_en_i     (en),
        .filt_len_i   (flen),
        .glitch_clr_i (clr),
        .intreq_nmi_o (intreq),
        .nmi_glitch_o (glitch)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_edge();
        logic [N-1:0] synced;
        logic         nrm;
        if (!rst_n) begin
            m_acc = '0;
            m_arm = '0;
            m_gl  = '0;
            for (int c = 0; c < N; c++) m_run[c] = 0;
            pipe.delete();
            pipe.push_back('0);
            pipe.push_back('0);
            return;
        end
        synced = pipe[0];
        for (int c = 0; c < N; c++) begin
            logic gset;
            gset = 1'b0;
            if (!en[c]) m_arm[c] = 1'b0;
            else if (!m_acc[c]) m_arm[c] = 1'b1;
            nrm = (synced[c] == pol[c]);
            if (nrm == m_acc[c]) begin
                gset     = (m_run[c] > 0);
                m_run[c] = 0;
            end else if (m_run[c] >= int'(flen)) begin
                m_acc[c] = nrm;
                m_run[c] = 0;
            end else begin
                m_run[c] = m_run[c] + 1;
            end
            if (clr[c]) m_gl[c] = 1'b0;
            else if (gset) m_gl[c] = 1'b1;
        end
        void'(pipe.pop_front());
        pipe.push_back(pin);
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, "_req"}, 32'(intreq), 32'(m_acc & m_arm & en));
        chk({tag, "_glitch"}, 32'(glitch), 32'(m_gl));
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        pin   = '0;
        pol   = '1;
        en    = '1;
        clr   = '0;
        flen  = '0;
        pipe.push_back('0);
        pipe.push_back('0);
        m_acc = '0;
        m_arm = '0;
        m_gl  = '0;
        for (int c = 0; c < N; c++) m_run[c] = 0;

        @(negedge clk);
        ticks("rst", 2);
        chk("reset_req", 32'(intreq), 32'h0);
        chk("reset_glitch", 32'(glitch), 32'h0);
        rst_n = 1'b1;
        ticks("settle", 4);

        // Bypass: filt_len 0, three-edge latency both ways.
        pin[0] = 1'b1;
        ticks("byp", 2);
        chk("byp_e2", 32'(intreq[0]), 32'h0);
        tick("byp");
        chk("byp_rise", 32'(intreq[0]), 32'h1);
        pin[0] = 1'b0;
        ticks("byp", 2);
        chk("byp_hold", 32'(intreq[0]), 32'h1);
        tick("byp");
        chk("byp_fall", 32'(intreq[0]), 32'h0);

        // Glitch: 3-cycle pulse with filt_len 3 never passes.
        flen   = 4'd3;
        pin[1] = 1'b1;
        ticks("glt", 3);
        pin[1] = 1'b0;
        ticks("glt", 8);
        chk("glt_out", 32'(intreq[1]), 32'h0);
        chk("glt_flag", 32'(glitch[1]), 32'h1);
        clr[1] = 1'b1;
        tick("glt");
        clr[1] = 1'b0;
        chk("glt_clr", 32'(glitch[1]), 32'h0);

        // Active-low channel.
        flen   = 4'd2;
        pol[2] = 1'b0;
        pin[2] = 1'b1;
        ticks("alo", 6);
        chk("alo_idle", 32'(intreq[2]), 32'h0);
        clr = '1;
        tick("alo");
        clr = '0;
        pin[2] = 1'b0;
        ticks("alo", 4);
        chk("alo_e4", 32'(intreq[2]), 32'h0);
        tick("alo");
        chk("alo_e5", 32'(intreq[2]), 32'h1);
        ticks("alo", 2);
        pin[2] = 1'b1;
        ticks("alo", 6);

        // Arm: enabling on an already-active level is held off.
        flen   = 4'd0;
        en[3]  = 1'b0;
        pin[3] = 1'b1;
        ticks("arm", 5);
        en[3] = 1'b1;
        ticks("arm", 3);
        chk("arm_block", 32'(intreq[3]), 32'h0);
        pin[3] = 1'b0;
        ticks("arm", 4);
        pin[3] = 1'b1;
        ticks("arm", 4);
        chk("arm_fire", 32'(intreq[3]), 32'h1);
        en[3] = 1'b0;
        #1;
        chk("en_drop", 32'(intreq[3]), 32'h0);
        tick("arm");

        // Reset mid-count discards the pending filter progress.
        en  = '1;
        pol = '1;
        pin = '0;
        clr = '1;
        ticks("pre", 6);
        clr  = '0;
        flen = 4'd7;
        pin[0] = 1'b1;
        ticks("rmc", 4);
        rst_n = 1'b0;
        tick("rmc");
        chk("rmc_req", 32'(intreq), 32'h0);
        chk("rmc_glitch", 32'(glitch), 32'h0);
        rst_n = 1'b1;
        ticks("rmc", 9);
        chk("rmc_e9", 32'(intreq[0]), 32'h0);
        tick("rmc");
        chk("rmc_e10", 32'(intreq[0]), 32'h1);

        // Boundary: maximum filter length, then lowering it mid-count.
        flen   = 4'd15;
        pin[1] = 1'b1;
        ticks("max", 17);
        chk("max_e17", 32'(intreq[1]), 32'h0);
        tick("max");
        chk("max_e18", 32'(intreq[1]), 32'h1);
        pin[1] = 1'b0;
        ticks("low", 11);
        chk("low_e11", 32'(intreq[1]), 32'h1);
        flen = 4'd2;
        tick("low");
        chk("low_accept", 32'(intreq[1]), 32'h0);

        // Randomised phase against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(5) == 0)  pin[c] = ~pin[c];
                if ($urandom_range(60) == 0) pol[c] = ~pol[c];
                if ($urandom_range(40) == 0) en[c]  = ~en[c];
                clr[c] = ($urandom_range(15) == 0);
            end
            if ($urandom_range(80) == 0) flen = FW'($urandom_range(4));
            if ($urandom_range(400) == 0) flen = FW'($urandom_range(15));
            rst_n = ($urandom_range(300) != 0);
            #1;
            chk("rnd_comb", 32'(intreq), 32'(m_acc & m_arm & en));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intc_nmi_filter.md
# intc_nmi_filter

Per-CPU NMI input conditioner sitting directly upstream of the NMI capture stage in the interrupt controller. It synchronises each raw external NMI pin into `clk`, normalises its polarity, and rejects glitches with a programmable stability filter. It gates the result with an arm/enable mechanism and drives a clean, glitch-free active-high level per CPU. The downstream capture stage edge-detects that level and holds the request until CPU acknowledge.

## Interface
- `CPU_NUM`, default 4: number of NMI channels, one per CPU.
- `FILT_W`, default 4: width of the filter length and of the per-channel stability counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `nmi_pin_i`  in  CPU_NUM  raw asynchronous NMI pins.
- `nmi_pol_i`  in  CPU_NUM  per-channel polarity: 1 = pin active-high, 0 = active-low. Quasi-static, register-driven.
- `nmi_en_i`  in  CPU_NUM  per-channel enable. Register-driven.
- `filt_len_i`  in  FILT_W  extra stable cycles required before a level change is accepted. 0 means the change is accepted on the first differing synchronised sample.
- `glitch_clr_i`  in  CPU_NUM  clears the per-channel sticky glitch flag (one-cycle pulse).
- `intreq_nmi_o`  out  CPU_NUM  filtered, armed, active-high NMI level to the capture stage.
- `nmi_glitch_o`  out  CPU_NUM  sticky flag: a pending level change was abandoned.

## Operation
Each channel is independent.

**Synchronisation and polarity**
- 2-flop synchroniser: `s1 <= pin`, `s2 <= s1`.
- Normalised level: `norm = s2 XNOR pol`.

**Stability filter.** State is `stable_q` (accepted level) and `cnt` (FILT_W bits).
- `norm == stable_q`: `cnt <= 0`. If `cnt != 0` at that moment, set `glitch_q`.
- `norm != stable_q` and `cnt >= filt_len_i`: `stable_q <= norm`, `cnt <= 0`.
- Otherwise: `cnt <= cnt + 1`.
- Because the comparison is `>=`, `cnt` never wraps. Lowering `filt_len_i` mid-count completes the acceptance on the next differing cycle.

**Arm logic**
- `armed_q` sets when `nmi_en_i = 1` and `stable_q = 0`. It clears when `nmi_en_i = 0`.
- Enabling a channel while its level is already active therefore produces no request until the level has been seen inactive.

**Outputs**
- `intreq_nmi_o = stable_q & armed_q & nmi_en_i`. This is a combinational AND of flops and a register-driven enable.
- `glitch_q`: `glitch_clr_i` wins over a simultaneous set.
- The filter runs regardless of enable.

**Reset** (`rst_n = 0` at an edge): `s1`, `s2`, `stable_q`, `cnt`, `armed_q` and `glitch_q` all go to 0. As a result `intreq_nmi_o = 0` and `nmi_glitch_o = 0` from the first edge with reset asserted. Reset mid-filter discards the pending count.

## Timing
- Pin change set up before edge E1: `s1` at E1, `s2` at E2, `stable_q` at E(3+filt_len). `intreq_nmi_o` is valid after that edge if armed.
- The same latency applies to deassertion.
- A pulse shorter than filt_len+1 synchronised cycles never reaches the output and sets the glitch flag.
- `nmi_en_i` falling forces the output low in the same cycle and clears `armed_q` at the next edge.
- `nmi_pol_i` change is treated as a level change and goes through the filter.
- The downstream capture stage adds its own edge and hold registers. This block performs no acknowledge handling.

## Structure
- Sub-module `intc_nmi_filter_ch` contains one channel (synchroniser, filter, arm, glitch flag). The top instantiates it CPU_NUM times via generate.
- Shared package `intc_pkg` holds the `CPU_NUM` default and the `FILT_W` default.
- Synchroniser flops carry the codebase's standard sync-cell attribute for CDC tooling.

## Test plan
- **Bypass:** `filt_len=0`, `pol=1`, `en=1`. Pin 0→1 before E1 → `intreq_nmi_o[0]=1` after E3. Pin 1→0 → output 0 three edges later.
- **Glitch:** `filt_len=3`. 3-cycle high pulse on pin[1] → output stays 0 and `nmi_glitch_o[1]=1`. `glitch_clr_i[1]` pulse → flag 0 on the next edge.
- **Active-low:** `pol[2]=0`. Pin held high → no request. Pin low for 5 cycles with `filt_len=2` → output 1 after E5.
- **Arm:** pin[3] active and filtered, `en` raised → output stays 0. Pin inactive then active again → output 1. `en` dropped → output 0 in the same cycle.
- **Reset mid-count:** `filt_len=7`, pin active for 4 cycles, `rst_n=0` for 1 edge → all outputs 0. The count restarts, and the output rises only after 10 further stable edges (2 synchroniser edges + 8 filter edges).
- **Boundary:** `filt_len=15` with the counter saturating at 15 and no wrap → accepted at E18. `filt_len` lowered from 15 to 2 while `cnt=9` → accepted on the next edge.
